// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the round-robin arbiter and its eight clients.
// The arbiter takes the slave side; the client cluster takes the master side.
interface rr_arbiter_8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with bounded hold time. Every output is registered.
// Releasing owners drop to lowest priority, and handover is back-to-back.
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input logic           clk,
  input logic           rst_n,
  rr_arbiter_8_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] idx, idx_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       valid, valid_nxt;
  logic       timeout, timeout_nxt;
  logic [7:0] gnt, gnt_nxt;

  logic       hold_end, owner_req, rel, forced;
  logic [2:0] next_ptr;
  logic [3:0] win_idle, win_rel;

  // Bit 3 flags a winner; bits 2:0 give its index. The downward loop lets the
  // lowest offset from p overwrite every later candidate.
  function automatic logic [3:0] arbitrate(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] k;
    res = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      k = p + 3'(i);
      if (r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  function automatic logic [7:0] decode(input logic [2:0] i);
    return 8'b0000_0001 << i;
  endfunction

  assign hold_end  = (cnt == HOLD_LAST);
  assign owner_req = bus.req[idx];
  assign rel       = bus.done | ~owner_req | hold_end;
  assign forced    = hold_end & ~bus.done & owner_req;
  assign next_ptr  = idx + 3'd1;
  assign win_idle  = arbitrate(bus.req, ptr);
  assign win_rel   = arbitrate(bus.req, next_ptr);

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    valid_nxt   = valid;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (win_idle[3]) begin
          idx_nxt   = win_idle[2:0];
          valid_nxt = 1'b1;
          cnt_nxt   = 8'd0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_nxt     = next_ptr;
          timeout_nxt = forced;
          if (win_rel[3]) begin
            idx_nxt = win_rel[2:0];
            cnt_nxt = 8'd0;
          end else begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
    gnt_nxt = valid_nxt ? decode(idx_nxt) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      idx     <= 3'd0;
      cnt     <= 8'd0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      gnt     <= 8'h00;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      idx     <= idx_nxt;
      cnt     <= cnt_nxt;
      valid   <= valid_nxt;
      timeout <= timeout_nxt;
      gnt     <= gnt_nxt;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.gnt_idx   = idx;
  assign bus.gnt_valid = valid;
  assign bus.timeout   = timeout;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8. It drives a default-hold instance and a MAX_HOLD=4
// instance from the same stimulus.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;

  int tests = 0;
  int fails = 0;

  rr_arbiter_8_if bus16 ();
  rr_arbiter_8_if bus4 ();

  assign bus16.req  = req;
  assign bus16.done = done;
  assign bus4.req   = req;
  assign bus4.done  = done;

  rr_arbiter_8 #(.MAX_HOLD(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  rr_arbiter_8 #(.MAX_HOLD(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } vec_t;

  vec_t vecs [20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [7:0] g, input logic [2:0] i,
                       input logic v, input logic t);
    chk({name, ".gnt"},   bus16.gnt, g);
    chk({name, ".idx"},   8'(bus16.gnt_idx), 8'(i));
    chk({name, ".valid"}, 8'(bus16.gnt_valid), 8'(v));
    chk({name, ".to"},    8'(bus16.timeout), 8'(t));
  endtask

  task automatic chk4(input string name, input logic [7:0] g, input logic t);
    chk({name, ".gnt"}, bus4.gnt, g);
    chk({name, ".to"},  8'(bus4.timeout), 8'(t));
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;

    // Reset with requests pending, rotation, idle, single request, wrap priority.
    vecs[0]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 8'hFF, 1'b1, 8'h02, 3'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 8'hFF, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 8'hFF, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 8'hFF, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 8'hFF, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 8'hFF, 1'b1, 8'h40, 3'd6, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 8'hFF, 1'b1, 8'h80, 3'd7, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 8'hFF, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 8'h00, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 8'h41, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 8'h41, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 8'h41, 1'b1, 8'h40, 3'd6, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 8'h00, 1'b0, 8'h00, 3'd6, 1'b0, 1'b0};

    for (int v = 0; v < 20; v++) begin
      rst_n = vecs[v].rst_n;
      req   = vecs[v].req;
      done  = vecs[v].done;
      step();
      chk16($sformatf("vec%0d", v), vecs[v].gnt, vecs[v].idx, vecs[v].valid, vecs[v].to);
    end

    // Forced release at the default hold: ptr=7 here, so requester 0 wins.
    req  = 8'h01;
    done = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step();
      chk16($sformatf("hold16_c%0d", c), 8'h01, 3'd0, 1'b1, 1'b0);
    end
    step();
    chk16("hold16_force", 8'h01, 3'd0, 1'b1, 1'b1);
    step();
    chk16("hold16_after", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    step();
    chk16("hold16_withdraw", 8'h00, 3'd0, 1'b0, 1'b0);

    // Reset during grant cycle 1 of requester 3.
    req = 8'h08;
    step();
    chk16("mid_g0", 8'h08, 3'd3, 1'b1, 1'b0);
    step();
    chk16("mid_g1", 8'h08, 3'd3, 1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    chk16("mid_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    req   = 8'h88;
    step();
    chk16("mid_regrant", 8'h08, 3'd3, 1'b1, 1'b0);
    done = 1'b1;
    step();
    chk16("mid_next", 8'h80, 3'd7, 1'b1, 1'b0);

    // Timeout on the MAX_HOLD=4 instance.
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    step();
    chk4("t4_rst", 8'h00, 1'b0);
    rst_n = 1'b1;
    req   = 8'h04;
    for (int c = 0; c < 4; c++) begin
      step();
      chk4($sformatf("t4_c%0d", c), 8'h04, 1'b0);
    end
    step();
    chk4("t4_force", 8'h04, 1'b1);
    for (int c = 1; c < 4; c++) begin
      step();
      chk4($sformatf("t4_w2_c%0d", c), 8'h04, 1'b0);
    end
    // done coinciding with the hold limit is an ordinary release.
    done = 1'b1;
    step();
    chk4("t4_done_at_limit", 8'h04, 1'b0);
    done = 1'b0;
    req  = 8'h00;
    step();
    chk4("t4_idle", 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-requester round-robin arbiter that shares one resource slot among eight clients. It issues a one-hot grant equivalent to a 3-to-8 decode of the winning index, gated by grant-valid as the enable. It sits in front of the decoder-selected datapath: it picks which output line is enabled, holds the grant until the owner finishes, and forces release after a bounded hold time.

## Interface
- MAX_HOLD, 16, maximum cycles one grant is held before forced release; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- req  input  8  request vector; bit i = requester i wants the resource.
- done  input  1  owner finished; ignored when gnt_valid=0.
- gnt  output  8  registered one-hot grant; equals decode(gnt_idx) when gnt_valid=1, else 8'h00.
- gnt_idx  output  3  registered index of current owner.
- gnt_valid  output  1  registered; 1 while a grant is held.
- timeout  output  1  registered one-cycle pulse after a forced release.

## Operation
- State: IDLE (gnt_valid=0) and GRANT (gnt_valid=1).
- Internal state:
  - ptr[2:0] is the highest-priority index.
  - cnt[7:0] is the hold counter.
- Arbitration function: scan req from ptr upward, modulo 8 (ptr, ptr+1, …, 7, 0, …, ptr-1). The first set bit wins.
- IDLE:
  - If req≠0, load the winner into gnt_idx, set gnt_valid=1, clear cnt to 0, and enter GRANT.
  - Otherwise stay in IDLE.
- GRANT: the release condition is any of:
  - done=1;
  - req[gnt_idx]=0, i.e. the owner withdrew;
  - cnt==MAX_HOLD-1 (forced release).
- GRANT, no release: cnt increments by 1; the grant is unchanged.
- GRANT, on release:
  - ptr ← gnt_idx+1, wrapping 7→0.
  - Re-arbitrate in the same edge with the new ptr, using the current req. The releasing requester is therefore lowest priority.
  - If any req is set, load the new grant directly (back-to-back, no idle cycle) with cnt ← 0.
  - Otherwise go to IDLE, with gnt_valid ← 0 and gnt ← 0.
- Forced release happens only if cnt==MAX_HOLD-1 and done=0 and req[gnt_idx]=1. In that case timeout ← 1 for exactly the next cycle; otherwise timeout ← 0.
- done and the hold limit in the same cycle count as a normal release: timeout stays 0.
- An owner withdrawing req also counts as a normal release: no timeout.
- MAX_HOLD=1: every grant lasts exactly 1 cycle. timeout pulses after each grant in which done=0 and req[gnt_idx]=1.
- gnt_idx is held at its last value in IDLE; consumers qualify it with gnt_valid.

## Timing
- Reset values (rst_n=0 at an edge): state IDLE, ptr=0, cnt=0, gnt=8'h00, gnt_idx=0, gnt_valid=0, timeout=0.
- Reset overrides everything, including mid-grant: outputs are zero in the cycle after the reset edge.
- After reset deassertion, the first grant goes to the lowest set index (ptr=0).
- Latency: req sampled in IDLE in cycle N gives gnt valid in cycle N+1. No combinational path from req or done to any output.
- Grant duration:
  - Released by done in cycle k of the grant (cycle 0 = first grant cycle): the grant is visible for k+1 cycles.
  - Forced: visible for exactly MAX_HOLD cycles.
- Back-to-back handover: the old grant's last cycle is immediately followed by the new grant's first cycle. gnt is never all-zero between them and never has two bits set.
- Fairness: with req=8'hFF held, each requester is granted once in every 8 consecutive grants.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req=8'hFF → gnt=00, gnt_valid=0, timeout=0 throughout. Release → cycle after first sampled edge shows gnt=8'h01, gnt_idx=0.
- Single request: in IDLE, req=8'h20 at cycle N → cycle N+1 gnt=8'h20, gnt_idx=5. done=1 in grant cycle 2 → the next cycle has gnt_valid=0 and the grant lasted 3 cycles.
- Rotation: req=8'hFF held, done=1 every cycle → grant order 0,1,2,…,7,0, one per cycle, no idle gaps, never two bits set.
- Wrap priority: grant 6 released by done with req=8'h41 → next grant gnt_idx=0 (ptr=7 scans 7,0), then 6 after 0 releases.
- Timeout (MAX_HOLD=4):
  - req=8'h04 held, done=0 → gnt=8'h04 for exactly 4 cycles. Then timeout=1 for one cycle while 2 is re-granted (sole requester) with a fresh 4-cycle window.
  - Repeat with done=1 in grant cycle 3 → timeout stays 0.
- Reset mid-grant: rst_n=0 during grant cycle 1 of requester 3 → next cycle all outputs 0 and ptr=0. After release with req=8'h88 → grant goes to 3.
